// File: rtl/id_scoreboard_if.sv
// Decode-to-scoreboard bundle: instruction descriptor in, issue/stall decision out.
interface id_scoreboard_if #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned LAT_WIDTH  = 3
);
    logic                  id_valid_ip;
    logic [ADDR_WIDTH-1:0] src1_addr_ip;
    logic                  src1_used_ip;
    logic [ADDR_WIDTH-1:0] src2_addr_ip;
    logic                  src2_used_ip;
    logic [ADDR_WIDTH-1:0] dest_addr_ip;
    logic                  dest_we_ip;
    logic [LAT_WIDTH-1:0]  dest_lat_ip;
    logic                  ex_ready_ip;
    logic                  flush_ip;

    logic                  issue_op;
    logic                  stall_op;
    logic                  src1_busy_op;
    logic                  src2_busy_op;
    logic [NUM_REGS-1:0]   pending_mask_op;
    logic [31:0]           stall_cycles_op;

    // Decode side: presents the instruction, observes the decision.
    modport master (
        output id_valid_ip, src1_addr_ip, src1_used_ip, src2_addr_ip, src2_used_ip,
               dest_addr_ip, dest_we_ip, dest_lat_ip, ex_ready_ip, flush_ip,
        input  issue_op, stall_op, src1_busy_op, src2_busy_op, pending_mask_op,
               stall_cycles_op
    );

    // Scoreboard side.
    modport slave (
        input  id_valid_ip, src1_addr_ip, src1_used_ip, src2_addr_ip, src2_used_ip,
               dest_addr_ip, dest_we_ip, dest_lat_ip, ex_ready_ip, flush_ip,
        output issue_op, stall_op, src1_busy_op, src2_busy_op, pending_mask_op,
               stall_cycles_op
    );
endinterface

// File: rtl/id_scoreboard.sv
// Register scoreboard for decode: per-register latency countdowns drive
// RAW/WAW stall detection, flushes cancel writes of young instructions, and
// stall cycles are counted for performance analysis.
module id_scoreboard #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned LAT_WIDTH  = 3,
    parameter int unsigned KILL_DEPTH = 2
) (
    input  logic           clock,
    input  logic           reset,
    id_scoreboard_if.slave sb
);
    // Lookup table covers the full address space so any address indexes safely.
    localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
    localparam int unsigned AGE_WIDTH   = 3;
    localparam int unsigned STALL_WIDTH = 32;
    localparam logic [AGE_WIDTH-1:0] KILL_AGE = AGE_WIDTH'(KILL_DEPTH);

    logic [LAT_WIDTH-1:0]   count_view [DEPTH];
    logic [NUM_REGS-1:0]    pending_mask;
    logic                   src1_busy_c;
    logic                   src2_busy_c;
    logic                   waw_c;
    logic                   stall_c;
    logic                   issue_c;
    logic                   load_c;
    logic [STALL_WIDTH-1:0] stall_cycles_q;

    // Hazard detection and issue decision from registered counts.
    always_comb begin
        src1_busy_c = 1'b0;
        src2_busy_c = 1'b0;
        waw_c       = 1'b0;
        stall_c     = 1'b0;
        issue_c     = 1'b0;
        load_c      = 1'b0;

        src1_busy_c = sb.src1_used_ip && (sb.src1_addr_ip != '0)
                      && (count_view[sb.src1_addr_ip] != '0);
        src2_busy_c = sb.src2_used_ip && (sb.src2_addr_ip != '0)
                      && (count_view[sb.src2_addr_ip] != '0);
        // A new write must not complete before an older in-flight write to rd.
        waw_c       = sb.dest_we_ip && (sb.dest_addr_ip != '0)
                      && (count_view[sb.dest_addr_ip] > sb.dest_lat_ip);

        // A redirect overrides any stall so fetch can move to the new target.
        if (sb.id_valid_ip && !sb.flush_ip) begin
            stall_c = src1_busy_c || src2_busy_c || waw_c || !sb.ex_ready_ip;
        end
        issue_c = sb.id_valid_ip && !stall_c && !sb.flush_ip;
        load_c  = issue_c && sb.dest_we_ip && (sb.dest_addr_ip != '0);
    end

    // Per-register countdown and age; x0 and unimplemented addresses read as idle.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        if (g == 0 || g >= NUM_REGS) begin : g_const
            assign count_view[g] = '0;
        end else begin : g_reg
            logic [LAT_WIDTH-1:0] count_q;
            logic [AGE_WIDTH-1:0] age_q;
            logic                 hit_c;

            assign hit_c = load_c && (sb.dest_addr_ip == ADDR_WIDTH'(g));

            // Flush kill of young producers, then issue load, then countdown.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    count_q <= '0;
                    age_q   <= KILL_AGE;
                end else if (sb.flush_ip && (age_q < KILL_AGE)) begin
                    count_q <= '0;
                    age_q   <= KILL_AGE;
                end else if (hit_c) begin
                    count_q <= sb.dest_lat_ip;
                    age_q   <= '0;
                end else begin
                    if (count_q != '0) begin
                        count_q <= count_q - LAT_WIDTH'(1);
                    end
                    if (age_q < KILL_AGE) begin
                        age_q <= age_q + AGE_WIDTH'(1);
                    end else begin
                        age_q <= KILL_AGE;
                    end
                end
            end

            assign count_view[g] = count_q;
        end
    end

    // Pending bit per architectural register.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pending
        assign pending_mask[g] = (count_view[g] != '0);
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
        end else if (stall_c && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + STALL_WIDTH'(1);
        end
    end

    assign sb.issue_op        = issue_c;
    assign sb.stall_op        = stall_c;
    assign sb.src1_busy_op    = src1_busy_c;
    assign sb.src2_busy_op    = src2_busy_c;
    assign sb.pending_mask_op = pending_mask;
    assign sb.stall_cycles_op = stall_cycles_q;
endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed scenarios followed by random traffic,
// all checked against a per-register countdown model.
module tb_id_scoreboard;
    localparam int unsigned NR = 32;
    localparam int unsigned KD = 2;

    logic clock;
    logic reset;

    id_scoreboard_if #(.NUM_REGS(32), .ADDR_WIDTH(5), .LAT_WIDTH(3)) sb ();

    id_scoreboard #(.NUM_REGS(32), .ADDR_WIDTH(5), .LAT_WIDTH(3), .KILL_DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int     checks = 0;
    int     errors = 0;
    int     m_cnt [NR];
    int     m_age [NR];
    longint m_stalls;
    logic   last_issue;
    logic   last_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NR); i++) begin
            m_cnt[i] = 0;
            m_age[i] = KD;
        end
        m_stalls = 0;
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < int'(NR); i++) m[i] = (m_cnt[i] != 0);
        return m;
    endfunction

    // One clock cycle: called 1 time unit after a rising edge, returns likewise.
    task automatic cyc(input string tag, input logic v, input int a1, input logic u1,
                       input int a2, input logic u2, input int d, input logic we,
                       input int lat, input logic rdy, input logic fl);
        logic b1, b2, waw, stall, issue;
        sb.id_valid_ip  = v;
        sb.src1_addr_ip = 5'(a1);
        sb.src1_used_ip = u1;
        sb.src2_addr_ip = 5'(a2);
        sb.src2_used_ip = u2;
        sb.dest_addr_ip = 5'(d);
        sb.dest_we_ip   = we;
        sb.dest_lat_ip  = 3'(lat);
        sb.ex_ready_ip  = rdy;
        sb.flush_ip     = fl;
        #3;
        b1    = u1 && a1 != 0 && m_cnt[a1] != 0;
        b2    = u2 && a2 != 0 && m_cnt[a2] != 0;
        waw   = we && d != 0 && m_cnt[d] > lat;
        stall = v && !fl && (b1 || b2 || waw || !rdy);
        issue = v && !stall && !fl;
        check({tag, ".issue"},   64'(sb.issue_op),        64'(issue));
        check({tag, ".stall"},   64'(sb.stall_op),        64'(stall));
        check({tag, ".busy1"},   64'(sb.src1_busy_op),    64'(b1));
        check({tag, ".busy2"},   64'(sb.src2_busy_op),    64'(b2));
        check({tag, ".pending"}, 64'(sb.pending_mask_op), 64'(model_mask()));
        check({tag, ".stalls"},  64'(sb.stall_cycles_op), 64'(m_stalls));
        last_issue = sb.issue_op;
        last_stall = sb.stall_op;
        @(posedge clock);
        for (int i = 1; i < int'(NR); i++) begin
            if (fl && m_age[i] < KD) begin
                m_cnt[i] = 0;
                m_age[i] = KD;
            end else if (issue && we && i == d) begin
                m_cnt[i] = lat;
                m_age[i] = 0;
            end else begin
                if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                m_age[i] = (m_age[i] + 1 > KD) ? KD : m_age[i] + 1;
            end
        end
        if (stall && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before the next edge.
    task automatic do_reset(input string tag);
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        check({tag, ".pending"}, 64'(sb.pending_mask_op), 64'd0);
        check({tag, ".stalls"},  64'(sb.stall_cycles_op), 64'd0);
        check({tag, ".issue"},   64'(sb.issue_op),        64'd0);
        check({tag, ".stall"},   64'(sb.stall_op),        64'd0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        sb.id_valid_ip  = 1'b0;
        sb.src1_addr_ip = '0;
        sb.src1_used_ip = 1'b0;
        sb.src2_addr_ip = '0;
        sb.src2_used_ip = 1'b0;
        sb.dest_addr_ip = '0;
        sb.dest_we_ip   = 1'b0;
        sb.dest_lat_ip  = '0;
        sb.ex_ready_ip  = 1'b1;
        sb.flush_ip     = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check("reset.pending", 64'(sb.pending_mask_op), 64'd0);
        check("reset.stalls",  64'(sb.stall_cycles_op), 64'd0);
        check("reset.issue",   64'(sb.issue_op),        64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Countdown visibility: rd=5 lat=3 pending for three cycles.
        cyc("cd0", 1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 3, 1'b1, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            check("cd.bit5", 64'(sb.pending_mask_op[5]), 64'd1);
            idle("cd");
        end
        check("cd.clear", 64'(sb.pending_mask_op[5]), 64'd0);

        // RAW stall on rs1 until the producer's count expires.
        do_reset("rst_raw");
        cyc("raw0", 1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 2, 1'b1, 1'b0);
        n = 0;
        do begin
            cyc("raw", 1'b1, 7, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
            n++;
        end while (!last_issue && n < 10);
        check("raw.cycles", 64'(n), 64'd3);
        check("raw.stalls", 64'(sb.stall_cycles_op), 64'd2);

        // x0 writes create nothing; unused busy source does not stall.
        cyc("x0w", 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 5, 1'b1, 1'b0);
        check("x0.mask", 64'(sb.pending_mask_op), 64'd0);
        cyc("x0r", 1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b0);
        check("x0.issue", 64'(last_issue), 64'd1);
        cyc("p9", 1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 4, 1'b1, 1'b0);
        cyc("nouse", 1'b1, 0, 1'b0, 9, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        check("nouse.issue", 64'(last_issue), 64'd1);

        // WAW: shorter write to a busy rd waits; longer one issues at once.
        do_reset("rst_waw");
        cyc("waw0", 1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 5, 1'b1, 1'b0);
        n = 0;
        do begin
            cyc("waw", 1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1, 1'b1, 1'b0);
            n++;
        end while (!last_issue && n < 10);
        check("waw.cycles", 64'(n), 64'd5);
        cyc("waw1", 1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 5, 1'b1, 1'b0);
        cyc("waw2", 1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 6, 1'b1, 1'b0);
        check("waw.long", 64'(last_issue), 64'd1);

        // Flush kills the young producer only.
        do_reset("rst_fl");
        cyc("fl0", 1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 6, 1'b1, 1'b0);
        idle("fl1");
        cyc("fl2", 1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b1, 6, 1'b1, 1'b0);
        cyc("fl3", 1'b1, 0, 1'b0, 0, 1'b0, 10, 1'b1, 2, 1'b1, 1'b1);
        check("fl.issue", 64'(last_issue), 64'd0);
        check("fl.bit8",  64'(sb.pending_mask_op[8]), 64'd0);
        check("fl.bit3",  64'(sb.pending_mask_op[3]), 64'd1);
        check("fl.bit10", 64'(sb.pending_mask_op[10]), 64'd0);
        for (int c = 0; c < 3; c++) idle("fl_tail");
        check("fl.bit3_end", 64'(sb.pending_mask_op[3]), 64'd0);

        // Backpressure: no hazard but EX not ready -> stall, nothing loaded.
        cyc("bp", 1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 4, 1'b0, 1'b0);
        check("bp.stall", 64'(last_stall), 64'd1);
        check("bp.bit6",  64'(sb.pending_mask_op[6]), 64'd0);

        // Reset mid-countdown.
        cyc("mid", 1'b1, 0, 1'b0, 0, 1'b0, 12, 1'b1, 7, 1'b1, 1'b0);
        idle("mid1");
        do_reset("rst_mid");
        idle("post_rst");

        // Random traffic over a small register window to provoke hazards.
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset("rst_rand");
            cyc("rnd",
                1'($urandom_range(0, 9) < 8),
                int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)),
                1'($urandom_range(0, 9) != 0),
                1'($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
